// File: rtl/i2c_target_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_target_rx
// Brief    : I2C target receiver: START/STOP/address decode, write-data
//            capture with ACK. Optional read path via I2C_TARGET_READ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_rx #(
    parameter logic [6:0] TARGET_ADDR = 7'h3C,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
`ifdef I2C_TARGET_READ_EN
    input  logic [7:0] tx_data,
    output logic       tx_req,
`endif
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       stop_det,
    output logic       addr_nack
);
    localparam int c_FCW = $clog2(FILT_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX,
        S_RX_ACK,
        S_IGNORE
`ifdef I2C_TARGET_READ_EN
        , S_TX,
        S_TX_ACK
`endif
    } state_t;

    logic [1:0]             w_raw;
    logic [SYNC_STAGES-1:0] r_sync [2];
    logic [c_FCW-1:0]       r_fcnt [2];
    logic [1:0]             r_filt;
    logic [1:0]             r_filt_d;
    logic                   w_scl_f, w_sda_f;
    logic                   w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
    logic                   w_start, w_stop;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_oe, w_oe_nxt;
    logic       r_busy, w_busy_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_stop, w_stop_nxt;
    logic       r_nack, w_nack_nxt;
    logic       w_addr_ok;
`ifdef I2C_TARGET_READ_EN
    logic [7:0] r_tx_sh, w_tx_sh_nxt;
    logic       r_tx_req, w_tx_req_nxt;
`endif

    // Bit 1 carries scl, bit 0 carries sda through the conditioning path
    assign w_raw = {scl, sda};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= '1;
                r_fcnt[i] <= '0;
            end
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
        end else begin
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
                if (r_sync[i][SYNC_STAGES-1] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == c_FCW'(FILT_LEN - 1)) begin
                    r_filt[i] <= r_sync[i][SYNC_STAGES-1];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + c_FCW'(1);
                end
            end
        end
    end

    assign w_scl_f    = r_filt[1];
    assign w_sda_f    = r_filt[0];
    assign w_scl_rise =  r_filt[1] & ~r_filt_d[1];
    assign w_scl_fall = ~r_filt[1] &  r_filt_d[1];
    assign w_sda_rise =  r_filt[0] & ~r_filt_d[0];
    assign w_sda_fall = ~r_filt[0] &  r_filt_d[0];
    assign w_start    = w_sda_fall & w_scl_f;
    assign w_stop     = w_sda_rise & w_scl_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_shift    <= 8'h00;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_stop     <= 1'b0;
            r_nack     <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            r_tx_sh    <= 8'h00;
            r_tx_req   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_oe       <= w_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_stop     <= w_stop_nxt;
            r_nack     <= w_nack_nxt;
`ifdef I2C_TARGET_READ_EN
            r_tx_sh    <= w_tx_sh_nxt;
            r_tx_req   <= w_tx_req_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_oe_nxt       = r_oe;
        w_busy_nxt     = r_busy;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_stop_nxt     = 1'b0;
        w_nack_nxt     = 1'b0;
        w_addr_ok      = (r_shift[7:1] == TARGET_ADDR);
`ifdef I2C_TARGET_READ_EN
        w_tx_sh_nxt    = r_tx_sh;
        w_tx_req_nxt   = 1'b0;
`endif
        // Bus conditions override whatever byte is in flight
        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_stop_nxt  = 1'b1;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_RX: begin
                    if (w_scl_rise && r_cnt < 4'd8) begin
                        w_shift_nxt = {r_shift[6:0], w_sda_f};
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        if (r_state == S_RX) begin
                            w_oe_nxt       = 1'b1;
                            w_rx_data_nxt  = r_shift;
                            w_rx_valid_nxt = 1'b1;
                            w_state_nxt    = S_RX_ACK;
                        end else if (w_addr_ok && !r_shift[0]) begin
                            w_oe_nxt    = 1'b1;
                            w_state_nxt = S_ADDR_ACK;
`ifdef I2C_TARGET_READ_EN
                        end else if (w_addr_ok) begin
                            w_oe_nxt    = 1'b1;
                            w_state_nxt = S_ADDR_ACK;
`endif
                        end else begin
                            w_nack_nxt  = 1'b1;
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_busy_nxt = 1'b1;
                        w_cnt_nxt  = 4'd0;
`ifdef I2C_TARGET_READ_EN
                        // r_shift[0] still holds the R/W bit of the address
                        if (r_shift[0]) begin
                            w_tx_sh_nxt  = tx_data;
                            w_tx_req_nxt = 1'b1;
                            w_oe_nxt     = ~tx_data[7];
                            w_state_nxt  = S_TX;
                        end else begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = S_RX;
                        end
`else
                        w_oe_nxt    = 1'b0;
                        w_state_nxt = S_RX;
`endif
                    end
                end
                S_RX_ACK: begin
                    if (w_scl_fall) begin
                        w_oe_nxt    = 1'b0;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_RX;
                    end
                end
`ifdef I2C_TARGET_READ_EN
                S_TX: begin
                    if (w_scl_rise && r_cnt < 4'd8) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = S_TX_ACK;
                        end else begin
                            w_oe_nxt = ~r_tx_sh[3'(4'd7 - r_cnt)];
                        end
                    end
                end
                S_TX_ACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda_f) begin
                            w_tx_sh_nxt  = tx_data;
                            w_tx_req_nxt = 1'b1;
                            w_cnt_nxt    = 4'd0;
                            w_state_nxt  = S_TX;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign sda       = r_oe ? 1'b0 : 1'bz;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign busy      = r_busy;
    assign stop_det  = r_stop;
    assign addr_nack = r_nack;
`ifdef I2C_TARGET_READ_EN
    assign tx_req    = r_tx_req;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_rx
// Brief    : Self-checking bench for i2c_target_rx: vector table, corner-case
//            sequences and randomized transfers against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target_rx;
    localparam int Q = 30;  // quarter of a 100 kHz SCL period at 12 MHz

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       scl   = 1'b1;
    logic       m_sda = 1'b1;  // 1 = master releases the line
    wire        sda_bus;
    logic [7:0] rx_data;
    logic       rx_valid, busy, stop_det, addr_nack;

    pullup (sda_bus);
    assign sda_bus = m_sda ? 1'bz : 1'b0;

`ifdef I2C_TARGET_READ_EN
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
`endif

    i2c_target_rx dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda_bus),
`ifdef I2C_TARGET_READ_EN
        .tx_data   (tx_data),
        .tx_req    (tx_req),
`endif
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .stop_det  (stop_det),
        .addr_nack (addr_nack)
    );

    always #41.667 clk = ~clk;

    int         n_cmp = 0, n_bad = 0;
    int         n_valid = 0, n_stop = 0, n_nack = 0, n_wide = 0;
    logic [7:0] got_q[$];
    logic       pv = 1'b0, ps = 1'b0, pk = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                got_q.push_back(rx_data);
                n_valid++;
            end
            if (stop_det)  n_stop++;
            if (addr_nack) n_nack++;
            if ((rx_valid && pv) || (stop_det && ps) || (addr_nack && pk)) n_wide++;
        end
        pv = rx_valid;
        ps = stop_det;
        pk = addr_nack;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Works from idle and as a repeated START with scl low
    task automatic bus_start();
        m_sda = 1'b1; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        scl   = 1'b0; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    // Optional 40 ns scl glitch low during the high phase, with an sda blip inside it
    task automatic send_bit(input logic b, input logic glitch);
        m_sda = b; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        if (glitch) begin
            #5  scl   = 1'b0;
            #10 m_sda = ~b;
            #20 m_sda = b;
            #10 scl   = 1'b1;
        end
        wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic ack_clock(output logic ack);
        m_sda = 1'b1; wait_clk(Q);
        scl = 1'b1; wait_clk(Q);
        ack = sda_bus; wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gmask[i]);
        ack_clock(ack);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       aack;    // expected sda during address 9th clock (0 = ACK)
        logic       dack;    // expected sda during data 9th clock
        int         nvalid;
        int         nnack;
    } vec_t;

    initial begin
        vec_t       tbl[6];
        logic       ack;
        logic [7:0] exp_last;
        logic [7:0] rs_exp[3];
        logic [7:0] exp_q[$];
        logic [7:0] b, addr, d;
        int         v0, s0, k0, q0, nb, exp_nack, exp_stop;
        logic       match;

        tbl[0] = '{8'h78, 8'hA5, 1'b0, 1'b0, 1, 0};
        tbl[1] = '{8'h50, 8'h11, 1'b1, 1'b1, 0, 1};
        tbl[2] = '{8'h79, 8'h33, 1'b1, 1'b1, 0, 1};
        tbl[3] = '{8'h78, 8'h00, 1'b0, 1'b0, 1, 0};
        tbl[4] = '{8'h7A, 8'h3C, 1'b1, 1'b1, 0, 1};
        tbl[5] = '{8'h78, 8'hFF, 1'b0, 1'b0, 1, 0};
        rs_exp[0] = 8'h01; rs_exp[1] = 8'h02; rs_exp[2] = 8'h03;
        exp_last = 8'h00;

        // Reset and idle bus
        wait_clk(10);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_stop_det", stop_det, 0);
        check("rst_addr_nack", addr_nack, 0);
        rst = 1'b0;
        wait_clk(600);
        check("idle_sda", sda_bus, 1);
        check("idle_busy", busy, 0);
        check("idle_events", n_valid + n_stop + n_nack, 0);

        // Single-byte write vectors
        for (int t = 0; t < 6; t++) begin
            v0 = n_valid; s0 = n_stop; k0 = n_nack;
            bus_start();
            send_byte(tbl[t].addr, 8'h00, ack);
            check($sformatf("tbl%0d_addr_ack", t), ack, tbl[t].aack);
            check($sformatf("tbl%0d_busy", t), busy, !tbl[t].aack);
            send_byte(tbl[t].data, 8'h00, ack);
            check($sformatf("tbl%0d_data_ack", t), ack, tbl[t].dack);
            bus_stop();
            wait_clk(10);
            if (tbl[t].nvalid != 0) exp_last = tbl[t].data;
            check($sformatf("tbl%0d_valid", t), n_valid - v0, tbl[t].nvalid);
            check($sformatf("tbl%0d_rx_data", t), rx_data, exp_last);
            check($sformatf("tbl%0d_nack", t), n_nack - k0, tbl[t].nnack);
            check($sformatf("tbl%0d_stop", t), n_stop - s0, 1);
            check($sformatf("tbl%0d_busy_end", t), busy, 0);
            check($sformatf("tbl%0d_sda_end", t), sda_bus, 1);
        end

        // Repeated START between two writes
        v0 = n_valid; q0 = got_q.size();
        bus_start();
        send_byte(8'h78, 8'h00, ack); check("rs_addr1_ack", ack, 0);
        send_byte(8'h01, 8'h00, ack); check("rs_d1_ack", ack, 0);
        bus_start();
        check("rs_busy_drop", busy, 0);
        send_byte(8'h78, 8'h00, ack); check("rs_addr2_ack", ack, 0);
        check("rs_busy_again", busy, 1);
        send_byte(8'h02, 8'h00, ack); check("rs_d2_ack", ack, 0);
        send_byte(8'h03, 8'h00, ack); check("rs_d3_ack", ack, 0);
        bus_stop();
        wait_clk(10);
        check("rs_valid", n_valid - v0, 3);
        for (int k = 0; k < 3; k++)
            check($sformatf("rs_byte%0d", k), (q0 + k < got_q.size()) ? int'(got_q[q0 + k]) : -1, rs_exp[k]);
        exp_last = 8'h03;

        // Reset pulse during bit 4 of a data byte
        v0 = n_valid; s0 = n_stop;
        b = 8'h96;
        bus_start();
        send_byte(8'h78, 8'h00, ack); check("rm_addr_ack", ack, 0);
        check("rm_busy_before", busy, 1);
        for (int i = 7; i > 4; i--) send_bit(b[i], 1'b0);
        m_sda = b[4];
        wait_clk(5);
        rst = 1'b1;
        #1;
        check("rm_busy_async", busy, 0);
        check("rm_sda_released", sda_bus, 1);
        wait_clk(12);
        rst = 1'b0;
        exp_last = 8'h00;
        wait_clk(Q - 18);
        scl = 1'b1; wait_clk(2 * Q);
        scl = 1'b0; wait_clk(Q);
        for (int i = 3; i >= 0; i--) send_bit(b[i], 1'b0);
        ack_clock(ack);
        check("rm_abort_nack", ack, 1);
        bus_stop();
        wait_clk(10);
        check("rm_no_valid", n_valid - v0, 0);
        check("rm_stop", n_stop - s0, 1);
        check("rm_rx_data_cleared", rx_data, exp_last);
        bus_start();
        send_byte(8'h78, 8'h00, ack); check("rm2_addr_ack", ack, 0);
        send_byte(8'h5A, 8'h00, ack); check("rm2_data_ack", ack, 0);
        bus_stop();
        wait_clk(10);
        exp_last = 8'h5A;
        check("rm2_valid", n_valid - v0, 1);
        check("rm2_rx_data", rx_data, exp_last);

        // Glitches on scl at idle and inside address/data bits
        v0 = n_valid; s0 = n_stop; k0 = n_nack;
        @(negedge clk);
        #5  scl   = 1'b0;
        #10 m_sda = 1'b0;
        #20 m_sda = 1'b1;
        #10 scl   = 1'b1;
        wait_clk(20);
        check("gl_idle_events", (n_valid - v0) + (n_stop - s0) + (n_nack - k0), 0);
        check("gl_idle_busy", busy, 0);
        bus_start();
        send_byte(8'h78, 8'h20, ack); check("gl_addr_ack", ack, 0);
        send_byte(8'hC3, 8'h08, ack); check("gl_data_ack", ack, 0);
        bus_stop();
        wait_clk(10);
        exp_last = 8'hC3;
        check("gl_valid", n_valid - v0, 1);
        check("gl_rx_data", rx_data, exp_last);
        check("gl_stop", n_stop - s0, 1);
        check("gl_nack", n_nack - k0, 0);

        // Randomized transactions against a transaction-level model
        q0 = got_q.size(); s0 = n_stop; k0 = n_nack;
        exp_nack = 0; exp_stop = 0;
        for (int t = 0; t < 8; t++) begin
            addr  = ($urandom_range(0, 1) != 0) ? 8'h78 : 8'($urandom);
            match = (addr[7:1] == 7'h3C) && !addr[0];
            bus_start();
            send_byte(addr, 8'h00, ack);
            check($sformatf("rnd%0d_addr_ack", t), ack, !match);
            if (!match) exp_nack++;
            nb = $urandom_range(1, 2);
            for (int k = 0; k < nb; k++) begin
                d = 8'($urandom);
                send_byte(d, 8'h00, ack);
                check($sformatf("rnd%0d_d%0d_ack", t, k), ack, !match);
                if (match) exp_q.push_back(d);
            end
            if ($urandom_range(0, 3) != 0 || t == 7) begin
                bus_stop();
                exp_stop++;
            end
        end
        wait_clk(10);
        check("rnd_count", got_q.size() - q0, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("rnd_byte%0d", k), (q0 + k < got_q.size()) ? int'(got_q[q0 + k]) : -1, exp_q[k]);
        check("rnd_nack", n_nack - k0, exp_nack);
        check("rnd_stop", n_stop - s0, exp_stop);
        check("strobe_width", n_wide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
